// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared types and default widths for the I2C request arbiter.
// Latency: none, this file holds types and constants only.
// Backpressure: none, this file holds types and constants only.
package i2c_arb_pkg;

   localparam int I2C_ADDR_W = 7;
   localparam int I2C_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ERR_OK      = 2'b00,
      ERR_NACK    = 2'b01,
      ERR_TIMEOUT = 2'b10
   } err_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin picker, first set req bit scanning upward from ptr with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to act on the pick.
// Ports: req (request vector), ptr (scan start index), gnt (one-hot pick),
//        idx (binary pick), valid (any request set).
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   logic [N-1:0] rot;
   int           sum;

   always_comb begin
      // Rotate so that bit 0 of rot is req[ptr]; the first set bit is the winner.
      rot   = N'({req, req} >> ptr);
      sum   = 0;
      idx   = '0;
      valid = 1'b0;
      gnt   = '0;
      for (int k = 0; k < N; k++) begin
         if (!valid && rot[k]) begin
            valid = 1'b1;
            sum   = int'(ptr) + k;
            if (sum >= N) sum = sum - N;
            idx   = IDX_W'(sum);
         end
      end
      if (valid) gnt = N'(1) << idx;
   end

endmodule

// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: shares one i2c_master command port between NUM_REQ requesters.
// Latency: gnt -> m_start 1 cycle; m_done -> rsp_valid 1 cycle; watchdog aborts after TIMEOUT_CYC in WAIT.
// Backpressure: no grant while the master reports m_busy or while a command is in flight.
// Ports: req/req_addr/req_rw/req_wdata in, gnt out (per requester); rsp_* out (completion
//        to the granted requester); m_* to/from the i2c_master; busy high outside IDLE.
module i2c_req_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int ADDR_W      = I2C_ADDR_W,
   parameter int DATA_W      = I2C_DATA_W,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ-1:0]         req_rw,
   input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]         gnt,
   output logic                       rsp_valid,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id,
   output logic [DATA_W-1:0]          rsp_rdata,
   output logic [1:0]                 rsp_err,
   output logic                       m_start,
   output logic [ADDR_W-1:0]          m_addr,
   output logic                       m_rw,
   output logic [DATA_W-1:0]          m_wdata,
   output logic                       m_abort,
   input  logic                       m_busy,
   input  logic                       m_done,
   input  logic                       m_nack,
   input  logic [DATA_W-1:0]          m_rdata,
   output logic                       busy
);

   localparam int               ID_W     = $clog2(NUM_REQ);
   localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_t             state, state_nxt;
   logic [ID_W-1:0]    ptr, id_q, pick_idx, next_ptr;
   logic [NUM_REQ-1:0] pick_gnt;
   logic               pick_valid;
   logic [CNT_W-1:0]   cnt;
   logic               accept, expire;

   rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (ID_W)
   ) u_pick (
      .req   (req),
      .ptr   (ptr),
      .gnt   (pick_gnt),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // Strobes are gated by rst so a reset landing mid-command produces no
   // grant, start, abort or response pulse in that cycle.
   assign accept   = (state == IDLE) && pick_valid && !m_busy && !rst;
   // m_done in the final watchdog cycle takes priority over the abort.
   assign expire   = (state == WAIT) && !m_done && (cnt == CNT_LAST) && !rst;
   assign busy     = (state != IDLE);
   assign next_ptr = ID_W'((int'(id_q) + 1) % NUM_REQ);

   always_comb begin
      state_nxt = state;
      gnt       = '0;
      m_start   = 1'b0;
      m_abort   = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               gnt       = pick_gnt;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            m_start   = !rst;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (m_done) begin
               state_nxt = RESP;
            end else if (expire) begin
               m_abort   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid = !rst;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= '0;
         id_q      <= '0;
         cnt       <= '0;
         m_addr    <= '0;
         m_rw      <= 1'b0;
         m_wdata   <= '0;
         rsp_id    <= '0;
         rsp_rdata <= '0;
         rsp_err   <= ERR_OK;
      end else begin
         if (accept) begin
            id_q    <= pick_idx;
            m_addr  <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            m_rw    <= req_rw[pick_idx];
            m_wdata <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
         end

         if (state == ISSUE)     cnt <= '0;
         else if (state == WAIT) cnt <= cnt + 1'b1;

         // Response fields update only when a command finishes, so they
         // hold their last values between completions.
         if (state == WAIT && m_done) begin
            rsp_id    <= id_q;
            rsp_err   <= m_nack ? ERR_NACK : ERR_OK;
            rsp_rdata <= (m_rw && !m_nack) ? m_rdata : '0;
         end else if (expire) begin
            rsp_id    <= id_q;
            rsp_err   <= ERR_TIMEOUT;
            rsp_rdata <= '0;
         end

         if (state == RESP) ptr <= next_ptr;
      end
   end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter: self-checking bench for i2c_req_arbiter with a small master model.
// Latency: n/a.
// Backpressure: m_busy driven by the bench to hold off grants.
module tb_i2c_req_arbiter;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [27:0] req_addr;
   logic [3:0]  req_rw;
   logic [31:0] req_wdata;
   logic [3:0]  gnt;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_rdata;
   logic [1:0]  rsp_err;
   logic        m_start;
   logic [6:0]  m_addr;
   logic        m_rw;
   logic [7:0]  m_wdata;
   logic        m_abort;
   logic        m_busy, m_done, m_nack;
   logic [7:0]  m_rdata;
   logic        busy;

   logic [6:0] p_addr  [4];
   logic       p_rw    [4];
   logic [7:0] p_wdata [4];

   assign req_addr  = {p_addr[3], p_addr[2], p_addr[1], p_addr[0]};
   assign req_rw    = {p_rw[3], p_rw[2], p_rw[1], p_rw[0]};
   assign req_wdata = {p_wdata[3], p_wdata[2], p_wdata[1], p_wdata[0]};

   int checks = 0;
   int errors = 0;
   int ptr_m  = 0;   // reference round-robin pointer

   // observations from the last run_txn
   logic [3:0] o_gnt;
   int         o_gnt_c, o_start_c, o_abort_c, o_rsp_c, o_ngnt, o_nstart, o_nabort, o_id;
   logic [6:0] o_addr;
   logic       o_rw;
   logic [7:0] o_wdata, o_rdata;
   logic [1:0] o_err;

   i2c_req_arbiter #(
      .NUM_REQ(4), .ADDR_W(7), .DATA_W(8), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
      .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .m_start(m_start), .m_addr(m_addr),
      .m_rw(m_rw), .m_wdata(m_wdata), .m_abort(m_abort), .m_busy(m_busy),
      .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [35:0] outv();
      return {gnt, rsp_valid, rsp_id, rsp_rdata, rsp_err, m_start, m_addr, m_rw, m_wdata, m_abort, busy};
   endfunction

   // Reference arbitration: first requesting index from p upward, modulo 4.
   function automatic int rr_winner(input int p, input logic [3:0] rv);
      for (int k = 0; k < 4; k++) if (rv[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   // Drives one transaction and records what the DUT did. The master answers
   // lat cycles after m_start (lat=0: never answers).
   task automatic run_txn(input logic [3:0] rv, input bit keep, input int lat,
                          input bit nack, input logic [7:0] rd);
      logic [3:0] req_r;
      req_r = rv;
      o_gnt = '0; o_gnt_c = -1; o_start_c = -1; o_abort_c = -1; o_rsp_c = -1;
      o_ngnt = 0; o_nstart = 0; o_nabort = 0; o_id = -1;
      o_addr = '0; o_rw = 1'b0; o_wdata = '0; o_rdata = '0; o_err = '0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         req     = req_r;
         m_busy  = 1'b0;
         m_done  = (o_start_c >= 0) && (lat > 0) && (c == o_start_c + lat);
         m_nack  = m_done ? nack : 1'b0;
         m_rdata = m_done ? rd : 8'hEE;
         #1;
         if (gnt != 4'b0) begin
            o_ngnt++;
            if (o_gnt_c < 0) begin o_gnt = gnt; o_gnt_c = c; end
            if (!keep) req_r = req_r & ~gnt;
         end
         if (m_start) begin
            o_nstart++;
            if (o_start_c < 0) begin
               o_start_c = c; o_addr = m_addr; o_rw = m_rw; o_wdata = m_wdata;
            end
         end
         if (m_abort) begin o_nabort++; o_abort_c = c; end
         if (rsp_valid) begin
            o_rsp_c = c; o_id = int'(rsp_id); o_rdata = rsp_rdata; o_err = rsp_err;
            break;
         end
      end
      req = '0; m_done = 1'b0; m_nack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '0; m_busy = 1'b0; m_done = 1'b0; m_nack = 1'b0; m_rdata = '0;
      for (int i = 0; i < 4; i++) begin p_addr[i] = '0; p_rw[i] = 1'b0; p_wdata[i] = '0; end
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (outv() !== 36'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", outv()); end
      @(negedge clk); rst = 1'b0; #1;
      checks++;
      if (outv() !== 36'd0) begin errors++; $display("FAIL post_reset_idle got %h want 0", outv()); end
      // m_done while IDLE must be ignored
      @(negedge clk); m_done = 1'b1; m_nack = 1'b1;
      @(negedge clk); m_done = 1'b0; m_nack = 1'b0; #1;
      checks++;
      if ({rsp_valid, busy, rsp_err} !== 4'b0) begin
         errors++; $display("FAIL done_in_idle got v=%b busy=%b err=%b want 0", rsp_valid, busy, rsp_err);
      end
      ptr_m = 0;
   endtask

   task automatic test_single_write();
      p_addr[2] = 7'h48; p_rw[2] = 1'b0; p_wdata[2] = 8'hA5;
      run_txn(4'b0100, 1'b0, 3, 1'b0, 8'hFF);
      checks++;
      if (o_gnt !== 4'b0100 || o_ngnt != 1) begin errors++; $display("FAIL wr_gnt got %b x%0d want 0100 x1", o_gnt, o_ngnt); end
      checks++;
      if (o_start_c != o_gnt_c + 1 || o_addr !== 7'h48 || o_wdata !== 8'hA5 || o_rw !== 1'b0) begin
         errors++; $display("FAIL wr_start got dly=%0d a=%h d=%h rw=%b want 1 48 a5 0", o_start_c - o_gnt_c, o_addr, o_wdata, o_rw);
      end
      checks++;
      if (o_rsp_c != o_start_c + 4 || o_id != 2 || o_err !== 2'b00 || o_rdata !== 8'h00) begin
         errors++; $display("FAIL wr_rsp got dly=%0d id=%0d err=%b rd=%h want 4 2 00 00", o_rsp_c - o_start_c, o_id, o_err, o_rdata);
      end
      ptr_m = 3;
   endtask

   task automatic test_read();
      p_addr[1] = 7'h1E; p_rw[1] = 1'b1; p_wdata[1] = 8'($urandom);
      run_txn(4'b0010, 1'b0, 5, 1'b0, 8'h3C);
      checks++;
      if (o_gnt !== 4'b0010 || o_addr !== 7'h1E || o_rw !== 1'b1) begin
         errors++; $display("FAIL rd_cmd got g=%b a=%h rw=%b want 0010 1e 1", o_gnt, o_addr, o_rw);
      end
      checks++;
      if (o_id != 1 || o_rdata !== 8'h3C || o_err !== 2'b00 || o_rsp_c != o_start_c + 6) begin
         errors++; $display("FAIL rd_rsp got id=%0d rd=%h err=%b dly=%0d want 1 3c 00 6", o_id, o_rdata, o_err, o_rsp_c - o_start_c);
      end
      ptr_m = 2;
   endtask

   task automatic test_round_robin();
      int exp_ord [5] = '{0, 1, 2, 3, 0};
      test_reset();
      for (int t = 0; t < 5; t++) begin
         run_txn(4'hF, 1'b1, 2 + t, 1'b0, 8'h10 + 8'(t));
         checks++;
         if (o_gnt !== (4'b0001 << exp_ord[t]) || o_id != exp_ord[t]) begin
            errors++; $display("FAIL rr_order[%0d] got g=%b id=%0d want idx %0d", t, o_gnt, o_id, exp_ord[t]);
         end
         checks++;
         if (o_ngnt != 1 || o_nstart != 1 || o_rsp_c < 0) begin
            errors++; $display("FAIL rr_single[%0d] got gnts=%0d starts=%0d rsp=%0d want 1 1 seen", t, o_ngnt, o_nstart, o_rsp_c);
         end
         ptr_m = (exp_ord[t] + 1) % 4;
      end
   endtask

   task automatic test_nack();
      p_addr[3] = 7'($urandom); p_rw[3] = 1'b1;
      run_txn(4'b1000, 1'b0, 6, 1'b1, 8'h77);
      checks++;
      if (o_id != 3 || o_err !== 2'b01 || o_rdata !== 8'h00 || o_nabort != 0) begin
         errors++; $display("FAIL nack_rsp got id=%0d err=%b rd=%h ab=%0d want 3 01 00 0", o_id, o_err, o_rdata, o_nabort);
      end
      ptr_m = 0;
   endtask

   task automatic test_timeout();
      p_rw[0] = 1'b1;
      run_txn(4'b0001, 1'b0, 0, 1'b0, 8'h00);
      checks++;
      if (o_nabort != 1 || o_abort_c != o_start_c + TO) begin
         errors++; $display("FAIL to_abort got n=%0d dly=%0d want 1 %0d", o_nabort, o_abort_c - o_start_c, TO);
      end
      checks++;
      if (o_rsp_c != o_start_c + TO + 1 || o_err !== 2'b10 || o_rdata !== 8'h00 || o_id != 0) begin
         errors++; $display("FAIL to_rsp got dly=%0d err=%b rd=%h id=%0d want %0d 10 00 0", o_rsp_c - o_start_c, o_err, o_rdata, o_id, TO + 1);
      end
      @(negedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL to_idle got busy=%b want 0", busy); end
      // m_done arriving in the last watchdog cycle wins
      run_txn(4'b0001, 1'b0, TO, 1'b0, 8'h5A);
      checks++;
      if (o_nabort != 0 || o_err !== 2'b00 || o_rdata !== 8'h5A || o_rsp_c != o_start_c + TO + 1) begin
         errors++; $display("FAIL to_corner got ab=%0d err=%b rd=%h dly=%0d want 0 00 5a %0d", o_nabort, o_err, o_rdata, o_rsp_c - o_start_c, TO + 1);
      end
      ptr_m = 1;
   endtask

   task automatic test_reset_mid_wait();
      bit seen, g;
      run_txn(4'b0100, 1'b0, 2, 1'b0, 8'h00);   // leaves pointer at 3
      req = 4'b1000; seen = 1'b0; g = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (g) req = '0;
         #1;
         if (gnt != 4'b0) g = 1'b1;
         if (m_start) begin seen = 1'b1; break; end
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL rst_setup got no m_start want m_start"); end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0; #1;
      checks++;
      if (outv() !== 36'd0) begin errors++; $display("FAIL rst_wait_outputs got %h want 0", outv()); end
      ptr_m = 0;
      m_busy = 1'b1; req = 4'b1001;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         checks++;
         if (gnt !== 4'b0 || rsp_valid !== 1'b0 || m_abort !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL busy_block[%0d] got g=%b v=%b ab=%b busy=%b want 0", c, gnt, rsp_valid, m_abort, busy);
         end
      end
      run_txn(4'b1001, 1'b0, 2, 1'b0, 8'h00);
      checks++;
      if (o_gnt !== 4'b0001 || o_id != rr_winner(ptr_m, 4'b1001)) begin
         errors++; $display("FAIL rst_ptr got g=%b id=%0d want 0001 0", o_gnt, o_id);
      end
      ptr_m = 1;
   endtask

   task automatic test_random();
      logic [3:0] rv;
      logic [7:0] rd, exp_rd;
      logic [1:0] exp_err;
      int lat, w, exp_dly;
      bit nack, answered;
      for (int it = 0; it < 24; it++) begin
         rv = 4'($urandom_range(1, 15));
         for (int i = 0; i < 4; i++) begin
            p_addr[i] = 7'($urandom); p_rw[i] = 1'($urandom); p_wdata[i] = 8'($urandom);
         end
         lat      = $urandom_range(1, TO + 3);
         nack     = ($urandom_range(0, 3) == 0);
         rd       = 8'($urandom);
         w        = rr_winner(ptr_m, rv);
         answered = (lat <= TO);
         exp_err  = !answered ? 2'b10 : (nack ? 2'b01 : 2'b00);
         exp_rd   = (answered && p_rw[w] && !nack) ? rd : 8'h00;
         exp_dly  = answered ? lat + 1 : TO + 1;
         run_txn(rv, 1'b0, lat, nack, rd);
         checks++;
         if (o_gnt !== (4'b0001 << w) || o_ngnt != 1) begin
            errors++; $display("FAIL rnd_gnt[%0d] got %b x%0d want idx %0d x1", it, o_gnt, o_ngnt, w);
         end
         checks++;
         if (o_start_c != o_gnt_c + 1 || o_nstart != 1 || o_addr !== p_addr[w] || o_rw !== p_rw[w] || o_wdata !== p_wdata[w]) begin
            errors++; $display("FAIL rnd_cmd[%0d] got a=%h rw=%b d=%h want %h %b %h", it, o_addr, o_rw, o_wdata, p_addr[w], p_rw[w], p_wdata[w]);
         end
         checks++;
         if (o_rsp_c != o_start_c + exp_dly || o_nabort != (answered ? 0 : 1) || (!answered && o_abort_c != o_start_c + TO)) begin
            errors++; $display("FAIL rnd_timing[%0d] got dly=%0d ab=%0d want %0d %0d", it, o_rsp_c - o_start_c, o_nabort, exp_dly, answered ? 0 : 1);
         end
         checks++;
         if (o_id != w || o_err !== exp_err || o_rdata !== exp_rd) begin
            errors++; $display("FAIL rnd_rsp[%0d] got id=%0d err=%b rd=%h want %0d %b %h", it, o_id, o_err, o_rdata, w, exp_err, exp_rd);
         end
         ptr_m = (w + 1) % 4;
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read();
      test_round_robin();
      test_nack();
      test_timeout();
      test_reset_mid_wait();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
Shares one i2c_master transaction port between NUM_REQ on-chip requesters, e.g. sensor poller, config loader and debug port. Round-robin grants one requester at a time and latches its single-byte command. Sequences the master through start, wait and completion, with a watchdog timeout. Returns read data and status to the granted requester only.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 7, I2C slave address width
DATA_W, 8, data byte width
TIMEOUT_CYC, 4096, clk cycles allowed in WAIT before abort (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req  in  NUM_REQ  per-requester request, level, held until its gnt bit is seen
req_addr  in  NUM_REQ*ADDR_W  packed slave addresses, slice i belongs to req[i]
req_rw  in  NUM_REQ  1=read, 0=write
req_wdata  in  NUM_REQ*DATA_W  packed write bytes
gnt  out  NUM_REQ  one-hot, 1-cycle pulse when a command is accepted
rsp_valid  out  1  1-cycle completion pulse
rsp_id  out  $clog2(NUM_REQ)  index of the completed requester
rsp_rdata  out  DATA_W  read byte, 0 for writes and errors
rsp_err  out  2  00 ok, 01 nack, 10 timeout
m_start  out  1  1-cycle command strobe to i2c_master
m_addr  out  ADDR_W  latched address, held stable from ISSUE to RESP
m_rw  out  1  latched direction
m_wdata  out  DATA_W  latched write byte
m_abort  out  1  1-cycle pulse on timeout, master returns to idle
m_busy  in  1  master busy
m_done  in  1  1-cycle master completion pulse
m_nack  in  1  valid with m_done
m_rdata  in  DATA_W  valid with m_done
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, rr pointer 0, timeout counter 0. Reset mid-transaction drops the command silently: no rsp_valid and no m_abort. The master is reset by the same rst.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE to ISSUE: taken when |req and !m_busy. Winner = first set req[i] scanning from ptr upward, wrapping modulo NUM_REQ. In the same cycle: gnt[winner]=1, and addr/rw/wdata/id latch into m_* regs. While m_busy=1, stay in IDLE with no gnt.
- ISSUE: m_start=1 for exactly this one cycle. Next state WAIT. Clear the counter.
- WAIT: counter increments each cycle.
  - m_done=1: capture m_rdata (forced to 0 if m_rw=0 or m_nack=1). rsp_err=01 if m_nack, else 00. Go to RESP.
  - m_done=0 and counter==TIMEOUT_CYC-1: m_abort=1 for one cycle, rsp_err=10, rdata=0, go to RESP.
  - m_done and timeout in the same cycle: m_done wins, no abort.
- RESP: rsp_valid=1 for one cycle with rsp_id/rsp_rdata/rsp_err. Set ptr = (id+1) mod NUM_REQ. Go to IDLE.
- rsp_* hold their values until the next RESP. m_addr/m_rw/m_wdata hold until the next grant.
- Latency: grant to m_start is 1 cycle; m_done to rsp_valid is 1 cycle. Minimum back-to-back spacing is 4 cycles plus the master time.
- A req bit dropped before its grant is a withdrawal, with no side effect. A req bit still high after its gnt is a new request and is only eligible again after round-robin rotation.
- m_done outside WAIT is ignored.
- Fairness: with all requesters active, each gets one grant per NUM_REQ transactions.

Decomposition:
- Package i2c_arb_pkg holds:
  - state_t enum {IDLE, ISSUE, WAIT, RESP}
  - err_t with ERR_OK=2'b00, ERR_NACK=2'b01, ERR_TIMEOUT=2'b10
  - default width constants I2C_ADDR_W=7, I2C_DATA_W=8
- One sub-module, rr_pick: combinational. Inputs req vector and ptr. Outputs one-hot gnt and binary index plus a valid flag. Reusable by other shared-resource arbiters.
- The FSM, latches and timeout counter stay in the top level.

Test Plan:
- Single write: req[2]=1 with addr 0x48, rw=0, wdata 0xA5. Then gnt=0100 one cycle; m_start the next cycle with m_addr=0x48, m_wdata=0xA5. Master model returns m_done; one cycle later rsp_valid, rsp_id=2, err=00, rdata=0x00.
- Read with data: req[1] read of 0x1E, master returns m_rdata=0x3C. Then rsp_rdata=0x3C, err=00, rsp_id=1.
- Round-robin: req=1111 held throughout. Grant order 0,1,2,3,0. Exactly one rsp_valid per grant, and there is never a second m_start before rsp_valid.
- NACK: master returns m_done with m_nack=1 on a read. Then err=01 and rdata=0.
- Timeout: TIMEOUT_CYC=16 and the master never responds. m_abort pulses exactly 16 cycles after m_start; the next cycle gives rsp_valid with err=10; state returns to IDLE. Corner case: m_done in cycle 16 gives err=00 and no m_abort.
- Reset mid-WAIT: assert rst during WAIT. All outputs are 0 the next cycle, with no rsp_valid. After release, req=0001 is granted with ptr=0 and m_busy=1 blocks the grant until it falls.
